// File: rtl/exe_stage_if.sv
// Signal bundle between the ID/EXE register, the execute stage and the
// EXE/MEM register, including forwarding inputs and branch outputs.
interface exe_stage_if;
  logic        freeze;
  logic [31:0] pc_in;
  logic [3:0]  execute_command_in;
  logic        mem_read_en_in;
  logic        mem_write_en_in;
  logic        wb_enable_in;
  logic        immediate_in;
  logic        branch_taken_in;
  logic        status_write_enable_in;
  logic [31:0] reg_file_in1;
  logic [31:0] reg_file_in2;
  logic [3:0]  dest_reg_in;
  logic [3:0]  status_reg_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_alu_result;
  logic [31:0] wb_value;

  logic        branch_taken_out;
  logic [31:0] branch_address;
  logic [3:0]  status_reg_out;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [3:0]  dest_reg_out;
  logic        mem_read_en_out;
  logic        mem_write_en_out;
  logic        wb_enable_out;

  // Upstream side: drives the decoded instruction, observes results.
  modport master (
    output freeze, pc_in, execute_command_in, mem_read_en_in, mem_write_en_in,
           wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in,
           reg_file_in1, reg_file_in2, dest_reg_in, status_reg_in,
           signed_immediate_in, shift_operand_in, sel_src1, sel_src2,
           mem_alu_result, wb_value,
    input  branch_taken_out, branch_address, status_reg_out, alu_result_out,
           store_data_out, dest_reg_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out
  );

  // Execute stage side.
  modport slave (
    input  freeze, pc_in, execute_command_in, mem_read_en_in, mem_write_en_in,
           wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in,
           reg_file_in1, reg_file_in2, dest_reg_in, status_reg_in,
           signed_immediate_in, shift_operand_in, sel_src1, sel_src2,
           mem_alu_result, wb_value,
    output branch_taken_out, branch_address, status_reg_out, alu_result_out,
           store_data_out, dest_reg_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out
  );
endinterface

// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, second-operand generation (rotated
// immediate / memory offset / barrel shift), ALU with NZCV flags, branch
// target adder, status register and the EXE/MEM pipeline register.
module exe_stage_module (
  input  logic       clk,
  input  logic       rst,
  exe_stage_if.slave bus
);

  logic [31:0] op1;
  logic [31:0] op2_reg;
  logic [31:0] val2;
  logic [63:0] rot_wide;
  logic [4:0]  sh_amt;
  logic [31:0] alu_result_next;
  logic [3:0]  flags_next;
  logic [31:0] op_b;
  logic        carry_0;
  logic [32:0] sum33;
  logic        arith_op;
  logic        valid_op;

  assign sh_amt = bus.shift_operand_in[11:7];

  // Forwarding muxes; code 11 deliberately falls back to the register file.
  always_comb begin
    op1     = bus.reg_file_in1;
    op2_reg = bus.reg_file_in2;
    case (bus.sel_src1)
      2'b01:   op1 = bus.mem_alu_result;
      2'b10:   op1 = bus.wb_value;
      default: op1 = bus.reg_file_in1;
    endcase
    case (bus.sel_src2)
      2'b01:   op2_reg = bus.mem_alu_result;
      2'b10:   op2_reg = bus.wb_value;
      default: op2_reg = bus.reg_file_in2;
    endcase
  end

  // Second operand: rotated 8-bit immediate, raw 12-bit memory offset, or shifted register.
  always_comb begin
    val2     = '0;
    rot_wide = '0;
    if (bus.immediate_in) begin
      rot_wide = {2{24'b0, bus.shift_operand_in[7:0]}} >> {bus.shift_operand_in[11:8], 1'b0};
      val2     = rot_wide[31:0];
    end else if (bus.mem_read_en_in || bus.mem_write_en_in) begin
      val2 = {20'b0, bus.shift_operand_in};
    end else if (sh_amt == 5'd0) begin
      val2 = op2_reg;
    end else begin
      case (bus.shift_operand_in[6:5])
        2'b00: val2 = op2_reg << sh_amt;
        2'b01: val2 = op2_reg >> sh_amt;
        2'b10: val2 = 32'($signed(op2_reg) >>> sh_amt);
        default: begin
          rot_wide = {op2_reg, op2_reg} >> sh_amt;
          val2     = rot_wide[31:0];
        end
      endcase
    end
  end

  // ALU: one shared 33-bit adder serves ADD/ADC/SUB/SBC (subtract = add inverted operand).
  always_comb begin
    alu_result_next = '0;
    flags_next      = bus.status_reg_in;
    op_b            = val2;
    carry_0         = 1'b0;
    arith_op        = 1'b0;
    valid_op        = 1'b1;
    case (bus.execute_command_in)
      4'b0001: alu_result_next = val2;
      4'b1001: alu_result_next = ~val2;
      4'b0110: alu_result_next = op1 & val2;
      4'b0111: alu_result_next = op1 | val2;
      4'b1000: alu_result_next = op1 ^ val2;
      4'b0010: arith_op = 1'b1;
      4'b0011: begin arith_op = 1'b1; carry_0 = bus.status_reg_in[1]; end
      4'b0100: begin arith_op = 1'b1; op_b = ~val2; carry_0 = 1'b1; end
      4'b0101: begin arith_op = 1'b1; op_b = ~val2; carry_0 = bus.status_reg_in[1]; end
      default: valid_op = 1'b0;
    endcase
    sum33 = {1'b0, op1} + {1'b0, op_b} + {32'b0, carry_0};
    if (arith_op) begin
      alu_result_next = sum33[31:0];
      flags_next[1]   = sum33[32];
      flags_next[0]   = (op1[31] == op_b[31]) && (sum33[31] != op1[31]);
    end
    if (valid_op) begin
      flags_next[3] = alu_result_next[31];
      flags_next[2] = (alu_result_next == 32'd0);
    end
  end

  // Branch target is combinational so IF can redirect in the same cycle.
  assign bus.branch_taken_out = bus.branch_taken_in;
  assign bus.branch_address   = bus.pc_in + {{6{bus.signed_immediate_in[23]}}, bus.signed_immediate_in, 2'b00};

  // Status register: loads new flags only for flag-setting instructions when not frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.status_reg_out <= 4'd0;
    end else if (bus.status_write_enable_in && !bus.freeze) begin
      bus.status_reg_out <= flags_next;
    end
  end

  // EXE/MEM pipeline register: captures every unfrozen cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_result_out   <= 32'd0;
      bus.store_data_out   <= 32'd0;
      bus.dest_reg_out     <= 4'd0;
      bus.mem_read_en_out  <= 1'b0;
      bus.mem_write_en_out <= 1'b0;
      bus.wb_enable_out    <= 1'b0;
    end else if (!bus.freeze) begin
      bus.alu_result_out   <= alu_result_next;
      bus.store_data_out   <= op2_reg;
      bus.dest_reg_out     <= bus.dest_reg_in;
      bus.mem_read_en_out  <= bus.mem_read_en_in;
      bus.mem_write_en_out <= bus.mem_write_en_in;
      bus.wb_enable_out    <= bus.wb_enable_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_module.sv
// Self-checking bench for exe_stage_module: directed cases plus randomized
// instructions checked against a bit-serial / wide-integer reference model.
module tb_exe_stage_module;

  logic clk;
  logic rst;
  exe_stage_if bus();

  exe_stage_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected state of the registered outputs
  logic [31:0] exp_alu, exp_store;
  logic [3:0]  exp_dest, exp_flags;
  logic        exp_mr, exp_mw, exp_wb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return bus.mem_alu_result;
    if (sel == 2'b10) return bus.wb_value;
    return rf;
  endfunction

  // Operand 2 built one bit-step at a time
  function automatic logic [31:0] model_val2(input logic [31:0] op2);
    logic [31:0] v;
    int n;
    if (bus.immediate_in) begin
      v = {24'b0, bus.shift_operand_in[7:0]};
      n = 2 * int'(bus.shift_operand_in[11:8]);
      repeat (n) v = {v[0], v[31:1]};
      return v;
    end
    if (bus.mem_read_en_in || bus.mem_write_en_in) return {20'b0, bus.shift_operand_in};
    v = op2;
    n = int'(bus.shift_operand_in[11:7]);
    case (bus.shift_operand_in[6:5])
      2'b00:   repeat (n) v = {v[30:0], 1'b0};
      2'b01:   repeat (n) v = {1'b0, v[31:1]};
      2'b10:   repeat (n) v = {v[31], v[31:1]};
      default: repeat (n) v = {v[0], v[31:1]};
    endcase
    return v;
  endfunction

  // ALU with flags from wide signed/unsigned integer arithmetic
  task automatic model_alu(input logic [31:0] op1, input logic [31:0] val2,
                           output logic [31:0] res, output logic [3:0] fl);
    longint a, b, sa, sb, s, ss, cin, borrow;
    logic c, v, arith, ok;
    a = longint'(op1); b = longint'(val2);
    sa = longint'($signed(op1)); sb = longint'($signed(val2));
    cin = bus.status_reg_in[1] ? 64'sd1 : 64'sd0;
    borrow = 1 - cin;
    c = bus.status_reg_in[1]; v = bus.status_reg_in[0];
    arith = 1'b0; ok = 1'b1; s = 0; ss = 0; res = '0;
    case (bus.execute_command_in)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0110: res = op1 & val2;
      4'b0111: res = op1 | val2;
      4'b1000: res = op1 ^ val2;
      4'b0010: begin s = a + b;       ss = sa + sb;       c = (s > 64'sd4294967295); arith = 1'b1; end
      4'b0011: begin s = a + b + cin; ss = sa + sb + cin; c = (s > 64'sd4294967295); arith = 1'b1; end
      4'b0100: begin s = a - b;          ss = sa - sb;          c = (a >= b);          arith = 1'b1; end
      4'b0101: begin s = a - b - borrow; ss = sa - sb - borrow; c = (a >= b + borrow); arith = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (arith) begin
      res = 32'(s);
      v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
    fl = ok ? {res[31], (res == 32'd0), c, v} : bus.status_reg_in;
  endtask

  task automatic clear_model();
    exp_alu = '0; exp_store = '0; exp_dest = '0; exp_flags = '0;
    exp_mr = 1'b0; exp_mw = 1'b0; exp_wb = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    chk({pfx, "_alu"},   bus.alu_result_out,   exp_alu);
    chk({pfx, "_store"}, bus.store_data_out,   exp_store);
    chk({pfx, "_dest"},  32'(bus.dest_reg_out), 32'(exp_dest));
    chk({pfx, "_ctrl"},  32'({bus.mem_read_en_out, bus.mem_write_en_out, bus.wb_enable_out}),
                         32'({exp_mr, exp_mw, exp_wb}));
    chk({pfx, "_flags"}, 32'(bus.status_reg_out), 32'(exp_flags));
  endtask

  task automatic set_defaults();
    bus.freeze = 1'b0; bus.pc_in = '0; bus.execute_command_in = '0;
    bus.mem_read_en_in = 1'b0; bus.mem_write_en_in = 1'b0; bus.wb_enable_in = 1'b0;
    bus.immediate_in = 1'b0; bus.branch_taken_in = 1'b0; bus.status_write_enable_in = 1'b0;
    bus.reg_file_in1 = '0; bus.reg_file_in2 = '0; bus.dest_reg_in = '0; bus.status_reg_in = '0;
    bus.signed_immediate_in = '0; bus.shift_operand_in = '0; bus.sel_src1 = '0; bus.sel_src2 = '0;
    bus.mem_alu_result = '0; bus.wb_value = '0;
  endtask

  // One instruction: check branch path, clock it, check registered outputs
  task automatic step(input string tag);
    logic [31:0] op1, op2, v2, res, bexp;
    logic [3:0]  fl;
    #1;
    bexp = bus.pc_in + 32'(longint'($signed(bus.signed_immediate_in)) * 4);
    chk({tag, "_baddr"}, bus.branch_address, bexp);
    chk({tag, "_btaken"}, 32'(bus.branch_taken_out), 32'(bus.branch_taken_in));
    op1 = fwd(bus.sel_src1, bus.reg_file_in1);
    op2 = fwd(bus.sel_src2, bus.reg_file_in2);
    v2  = model_val2(op2);
    model_alu(op1, v2, res, fl);
    @(posedge clk);
    if (!bus.freeze) begin
      exp_alu = res; exp_store = op2; exp_dest = bus.dest_reg_in;
      exp_mr = bus.mem_read_en_in; exp_mw = bus.mem_write_en_in; exp_wb = bus.wb_enable_in;
      if (bus.status_write_enable_in) exp_flags = fl;
    end
    #1;
    check_regs(tag);
    $display("txn %s cmd=%b frz=%0d op1=%h val2=%h alu=%h flags=%b baddr=%h",
             tag, bus.execute_command_in, bus.freeze, op1, v2, bus.alu_result_out,
             bus.status_reg_out, bus.branch_address);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic rst_pulse(input string tag);
    #1 rst = 1'b1;
    #1;
    clear_model();
    check_regs(tag);
    $display("txn %s async reset frz=%0d alu=%h flags=%b", tag, bus.freeze,
             bus.alu_result_out, bus.status_reg_out);
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus.freeze = ($urandom_range(0, 4) == 0);
    bus.pc_in = $urandom;
    bus.execute_command_in = 4'($urandom);
    bus.mem_read_en_in = ($urandom_range(0, 5) == 0);
    bus.mem_write_en_in = ($urandom_range(0, 5) == 0);
    bus.wb_enable_in = 1'($urandom);
    bus.immediate_in = ($urandom_range(0, 3) == 0);
    bus.branch_taken_in = 1'($urandom);
    bus.status_write_enable_in = 1'($urandom);
    bus.reg_file_in1 = $urandom;
    bus.reg_file_in2 = ($urandom_range(0, 3) == 0) ? bus.reg_file_in1 : $urandom;
    bus.dest_reg_in = 4'($urandom);
    bus.status_reg_in = 4'($urandom);
    bus.signed_immediate_in = 24'($urandom);
    bus.shift_operand_in = 12'($urandom);
    bus.sel_src1 = 2'($urandom);
    bus.sel_src2 = 2'($urandom);
    bus.mem_alu_result = $urandom;
    bus.wb_value = $urandom;
  endtask

  logic [31:0] held_alu;
  logic [3:0]  held_flags;

  initial begin
    rst = 1'b1;
    set_defaults();
    clear_model();
    #1;
    check_regs("reset0");
    bus.reg_file_in1 = 32'h1234; bus.execute_command_in = 4'b0001;
    bus.wb_enable_in = 1'b1; bus.status_write_enable_in = 1'b1;
    @(posedge clk);
    #1;
    check_regs("reset_hold");
    rst = 1'b0;

    // Signed overflow on ADD
    set_defaults();
    bus.execute_command_in = 4'b0010; bus.reg_file_in1 = 32'h7FFFFFFF;
    bus.immediate_in = 1'b1; bus.shift_operand_in = 12'h001; bus.status_write_enable_in = 1'b1;
    step("add_ovf");
    chk("add_ovf_const", bus.alu_result_out, 32'h80000000);
    chk("add_ovf_nzcv", 32'(bus.status_reg_out), 32'h9);

    // Equal SUB gives zero with carry (no borrow)
    set_defaults();
    bus.execute_command_in = 4'b0100; bus.reg_file_in1 = 32'd5;
    bus.immediate_in = 1'b1; bus.shift_operand_in = 12'h005; bus.status_write_enable_in = 1'b1;
    step("sub_zero");
    chk("sub_zero_const", bus.alu_result_out, 32'h0);
    chk("sub_zero_nzcv", 32'(bus.status_reg_out), 32'h6);

    // Rotated immediate MOV
    set_defaults();
    bus.execute_command_in = 4'b0001; bus.immediate_in = 1'b1; bus.shift_operand_in = 12'h2FF;
    step("mov_rot");
    chk("mov_rot_const", bus.alu_result_out, 32'hF000000F);
    chk("mov_rot_flags_held", 32'(bus.status_reg_out), 32'h6);

    // Forwarded op1 from writeback, register val2 LSL 1
    set_defaults();
    bus.execute_command_in = 4'b0010; bus.sel_src1 = 2'b10; bus.wb_value = 32'h10;
    bus.reg_file_in1 = 32'hDEAD0000; bus.reg_file_in2 = 32'h20; bus.shift_operand_in = 12'h080;
    bus.dest_reg_in = 4'd7; bus.wb_enable_in = 1'b1;
    step("fwd_add");
    chk("fwd_add_const", bus.alu_result_out, 32'h50);

    // Backward branch
    set_defaults();
    bus.branch_taken_in = 1'b1; bus.pc_in = 32'h100; bus.signed_immediate_in = 24'hFFFFFE;
    step("branch");
    chk("branch_const", bus.branch_address, 32'hF8);
    chk("branch_taken_const", 32'(bus.branch_taken_out), 32'h1);

    // Known capture, then two frozen cycles with changing inputs
    set_defaults();
    bus.execute_command_in = 4'b0111; bus.reg_file_in1 = 32'hA0A0; bus.immediate_in = 1'b1;
    bus.shift_operand_in = 12'h00F; bus.status_write_enable_in = 1'b1; bus.dest_reg_in = 4'd3;
    step("pre_freeze");
    held_alu = exp_alu; held_flags = exp_flags;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      bus.freeze = 1'b1; bus.status_write_enable_in = 1'b1;
      step("freeze");
      chk("freeze_alu_const", bus.alu_result_out, held_alu);
      chk("freeze_flags_const", 32'(bus.status_reg_out), 32'(held_flags));
    end
    rst_pulse("rst_frozen");
    bus.freeze = 1'b0;
    step("post_rst");

    // Randomized instruction stream with occasional freeze and reset
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      step($sformatf("rnd%0d", i));
      if ($urandom_range(0, 24) == 0) rst_pulse($sformatf("rnd%0d_rst", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
